fifo_sync_ext: RTL and testbench
================================

Name: fifo_sync_ext

Overview:
Parametrised single-clock FIFO that succeeds the power-of-2 synchronous FIFO.
- Depth is any integer ≥ 2, not limited to powers of 2.
- Read interface is selectable between FWFT and standard (registered, latency-1) mode.
- Full/empty watermarks are programmable at run time.
- Provides an exact occupancy count, a synchronous flush, and sticky overflow/underflow error flags.
- Used as the general-purpose buffer between streaming pipeline stages in one clock domain.

Parameters:
- DW, 8, data width in bits (≥ 1).
- DEPTH, 16, number of entries (≥ 2, any integer).
- FWFT, 1, read mode: 1 = first-word-fall-through, 0 = standard registered read.
- CW, derived localparam = clog2(DEPTH+1), width of count and threshold ports.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- clr  in  1  synchronous flush; empties FIFO and clears error flags.
- din  in  DW  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- pf_thresh  in  CW  prog_full threshold (entries).
- pe_thresh  in  CW  prog_empty threshold (entries).
- dout  out  DW  read data.
- dout_valid  out  1  FWFT=1: equals !empty. FWFT=0: one-cycle pulse marking new dout.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- prog_full  out  1  count ≥ pf_thresh.
- prog_empty  out  1  count ≤ pe_thresh.
- count  out  CW  occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset is synchronous, active-high, on rising clk.
  - Reset values: wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, prog_empty = 1, prog_full = (pf_thresh == 0), dout = 0, dout_valid = 0, overflow = 0, underflow = 0.
  - Memory array is not cleared.
- Write accept: we_ok = wr_en & !full. Read accept: re_ok = rd_en & !empty.
  - A write while full is dropped: no pointer or count change, overflow set.
  - A read while empty is ignored, underflow set.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
  - When full, the write is still dropped; full-gated accept has no read-through exception.
  - When empty, the read is ignored; the write still lands.
- Pointers range 0..DEPTH-1 and wrap explicitly to 0 after DEPTH-1. No modulo-2^n reliance.
- count is a registered up/down counter: +1 on we_ok only, −1 on re_ok only.
- Flags are registered, computed from the next value of count, so they are valid in the same cycle as count.
  - empty, full, prog_full, prog_empty all follow this rule.
  - Threshold comparisons are unsigned CW-bit.
  - pf_thresh > DEPTH means prog_full never asserts.
  - pe_thresh = 0 means prog_empty is identical to empty.
- FWFT=1 read path:
  - After the first write into an empty FIFO, empty falls at the next edge (1-cycle write→visible latency).
  - dout = mem[rd_ptr] while !empty, 0 while empty.
  - re_ok consumes the shown word; the next word is presented the following cycle.
- FWFT=0 read path:
  - On re_ok, dout is loaded with mem[rd_ptr] at that edge and dout_valid pulses high for exactly one cycle.
  - Without re_ok, dout holds its last value and dout_valid = 0.
- clr (priority: rst > clr > wr/rd):
  - Resets pointers, count, flags, dout_valid, overflow, underflow exactly as rst does.
  - dout is held, not zeroed.
  - wr_en/rd_en in the same cycle are discarded and do not set the error flags.
- Reset or clr asserted mid-stream: all in-flight data is lost. First write after deassertion lands at entry 0.
- Thresholds may change at any time; flags reflect new values from the next edge.

Test Plan:
- DEPTH=5, DW=8, FWFT=1, pf_thresh=4, pe_thresh=1:
  - Write 0x11..0x15 back-to-back → count 1..5; prog_empty low at count=2; prog_full high at count=4; full high after 5th write.
  - 6th write 0x16 → dropped, overflow=1, count stays 5.
- Same config: read 5 times → dout shows 0x11..0x15 in order, one per read; empty=1 after last read, dout=0.
  - Extra rd_en → underflow=1, count stays 0.
- Wrap-around, DEPTH=5: write 3 / read 3 repeated 4 times with data 0x00..0x0B → every word read back in order across the ptr 4→0 wrap; count never exceeds 3.
- Simultaneous rd_en & wr_en at count=5 (full) → read accepted, write dropped, overflow=1, count=4.
  - Simultaneous rd_en & wr_en at count=2 → count stays 2, data order preserved.
- FWFT=0: write 0xA5, 0x5A; assert rd_en one cycle → next cycle dout=0xA5 with dout_valid=1 for exactly one cycle.
  - Next rd_en → dout=0x5A; dout holds 0x5A afterwards with dout_valid=0.
- Flush and reset: at count=3 with overflow=1, assert clr together with wr_en → count=0, empty=1, overflow=0, write discarded.
  - rst mid-stream → all reset values; first write after release reads back correctly.

Source files
------------

// File: rtl/fifo_sync_ext.sv
// rtl/fifo_sync_ext.sv - single-clock FIFO with arbitrary depth, FWFT/standard read,
// programmable watermarks, exact count, flush and sticky error flags.
module fifo_sync_ext #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter bit FWFT  = 1'b1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [CW-1:0] pf_thresh,
  input  logic [CW-1:0] pe_thresh,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          empty,
  output logic          full,
  output logic          prog_full,
  output logic          prog_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] flag_count;
  logic          empty_q;
  logic          full_q;
  logic          prog_full_q;
  logic          prog_empty_q;
  logic          overflow_q;
  logic          underflow_q;
  logic          we_ok;
  logic          re_ok;
  logic          flush;

  assign flush = rst | clr;
  assign we_ok = wr_en & ~full_q;
  assign re_ok = rd_en & ~empty_q;

  always_comb begin
    count_nxt = count_q;
    case ({we_ok, re_ok})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Flags are registered from the post-edge count so they line up with count itself.
  assign flag_count = flush ? '0 : count_nxt;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_nxt;
      if (we_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (re_ok) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    empty_q      <= (flag_count == '0);
    full_q       <= (flag_count == CW'(DEPTH));
    prog_full_q  <= (flag_count >= pf_thresh);
    prog_empty_q <= (flag_count <= pe_thresh);
  end

  // Error flags only see requests that survive rst/clr priority.
  always_ff @(posedge clk) begin
    if (flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (wr_en & full_q);
      underflow_q <= underflow_q | (rd_en & empty_q);
    end
  end

  always_ff @(posedge clk) begin
    if (we_ok && !flush) mem[wr_ptr] <= din;
  end

  generate
    if (FWFT) begin : g_fwft
      assign dout       = empty_q ? '0 : mem[rd_ptr];
      assign dout_valid = ~empty_q;
    end else begin : g_std
      logic [DW-1:0] dout_q;
      logic          dv_q;

      // Flush leaves the last delivered word on dout; only a full reset zeroes it.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else if (clr) begin
          dv_q <= 1'b0;
        end else begin
          dv_q <= re_ok;
          if (re_ok) dout_q <= mem[rd_ptr];
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dv_q;
    end
  endgenerate

  assign empty      = empty_q;
  assign full       = full_q;
  assign prog_full  = prog_full_q;
  assign prog_empty = prog_empty_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ext.sv
// tb/tb_fifo_sync_ext.sv - directed bench for fifo_sync_ext, DEPTH=5 in FWFT and standard modes.
module tb_fifo_sync_ext;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_clr = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
  logic [7:0] a_din = 8'h00;
  logic [2:0] a_pf = 3'd4, a_pe = 3'd1;
  logic [7:0] a_dout;
  logic       a_dv, a_empty, a_full, a_pfull, a_pempty, a_ovf, a_unf;
  logic [2:0] a_count;

  logic       b_clr = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
  logic [7:0] b_din = 8'h00;
  logic [2:0] b_pf = 3'd4, b_pe = 3'd1;
  logic [7:0] b_dout;
  logic       b_dv, b_empty, b_full, b_pfull, b_pempty, b_ovf, b_unf;
  logic [2:0] b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sync_ext #(.DW(8), .DEPTH(5), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .clr(a_clr), .din(a_din), .wr_en(a_wr), .rd_en(a_rd),
    .pf_thresh(a_pf), .pe_thresh(a_pe), .dout(a_dout), .dout_valid(a_dv),
    .empty(a_empty), .full(a_full), .prog_full(a_pfull), .prog_empty(a_pempty),
    .count(a_count), .overflow(a_ovf), .underflow(a_unf)
  );

  fifo_sync_ext #(.DW(8), .DEPTH(5), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .clr(b_clr), .din(b_din), .wr_en(b_wr), .rd_en(b_rd),
    .pf_thresh(b_pf), .pe_thresh(b_pe), .dout(b_dout), .dout_valid(b_dv),
    .empty(b_empty), .full(b_full), .prog_full(b_pfull), .prog_empty(b_pempty),
    .count(b_count), .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [0:4] pe_exp;
    logic [0:4] pf_exp;
    logic [0:4] fl_exp;
    pe_exp = 5'b10000;
    pf_exp = 5'b00011;
    fl_exp = 5'b00001;

    // reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", 32'(a_count), 0);
    chk("rst_empty", 32'(a_empty), 1);
    chk("rst_full", 32'(a_full), 0);
    chk("rst_pempty", 32'(a_pempty), 1);
    chk("rst_pfull", 32'(a_pfull), 0);
    chk("rst_dout", 32'(a_dout), 0);
    chk("rst_dv", 32'(a_dv), 0);
    chk("rst_ovf", 32'(a_ovf), 0);
    chk("rst_unf", 32'(a_unf), 0);
    chk("rst_b_dout", 32'(b_dout), 0);
    chk("rst_b_dv", 32'(b_dv), 0);

    // fill 0x11..0x15
    for (int i = 0; i < 5; i++) begin
      a_din = 8'(8'h11 + i);
      a_wr  = 1'b1;
      tick();
      chk("fill_count", 32'(a_count), 32'(i + 1));
      chk("fill_pempty", 32'(a_pempty), 32'(pe_exp[i]));
      chk("fill_pfull", 32'(a_pfull), 32'(pf_exp[i]));
      chk("fill_full", 32'(a_full), 32'(fl_exp[i]));
      chk("fill_head", 32'(a_dout), 'h11);
    end
    a_din = 8'h16;
    tick();
    a_wr = 1'b0;
    chk("ovf_count", 32'(a_count), 5);
    chk("ovf_flag", 32'(a_ovf), 1);

    // drain
    for (int i = 0; i < 5; i++) begin
      chk("drain_dout", 32'(a_dout), 32'('h11 + i));
      chk("drain_dv", 32'(a_dv), 1);
      a_rd = 1'b1;
      tick();
      chk("drain_count", 32'(a_count), 32'(4 - i));
    end
    a_rd = 1'b0;
    chk("drain_empty", 32'(a_empty), 1);
    chk("drain_dout0", 32'(a_dout), 0);
    chk("drain_dv0", 32'(a_dv), 0);
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    chk("unf_flag", 32'(a_unf), 1);
    chk("unf_count", 32'(a_count), 0);
    chk("ovf_sticky", 32'(a_ovf), 1);

    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_ovf", 32'(a_ovf), 0);
    chk("clr_unf", 32'(a_unf), 0);

    // wrap-around: 4 rounds of write 3 / read 3
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) begin
        a_din = 8'(3 * r + j);
        a_wr  = 1'b1;
        tick();
        chk("wrap_count", 32'(a_count), 32'(j + 1));
      end
      a_wr = 1'b0;
      for (int j = 0; j < 3; j++) begin
        chk("wrap_dout", 32'(a_dout), 32'(3 * r + j));
        a_rd = 1'b1;
        tick();
      end
      a_rd = 1'b0;
      chk("wrap_empty", 32'(a_empty), 1);
    end

    // simultaneous read/write at full and at count=2
    for (int i = 0; i < 5; i++) begin
      a_din = 8'(8'h20 + i);
      a_wr  = 1'b1;
      tick();
    end
    chk("sim_full", 32'(a_full), 1);
    a_din = 8'h99; a_wr = 1'b1; a_rd = 1'b1;
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    chk("sim_full_count", 32'(a_count), 4);
    chk("sim_full_ovf", 32'(a_ovf), 1);
    chk("sim_full_dout", 32'(a_dout), 'h21);
    a_rd = 1'b1;
    tick(); tick();
    a_rd = 1'b0;
    chk("sim2_pre_count", 32'(a_count), 2);
    a_din = 8'h30; a_wr = 1'b1; a_rd = 1'b1;
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    chk("sim2_count", 32'(a_count), 2);
    chk("sim2_dout", 32'(a_dout), 'h24);
    a_rd = 1'b1;
    tick();
    chk("sim2_next", 32'(a_dout), 'h30);
    tick();
    a_rd = 1'b0;
    chk("sim2_empty", 32'(a_empty), 1);

    // flush at count=3 with overflow set, plus a concurrent write
    for (int i = 0; i < 3; i++) begin
      a_din = 8'(8'h41 + i);
      a_wr  = 1'b1;
      tick();
    end
    chk("fl_pre_count", 32'(a_count), 3);
    chk("fl_pre_ovf", 32'(a_ovf), 1);
    a_din = 8'h77; a_clr = 1'b1;
    tick();
    a_clr = 1'b0; a_wr = 1'b0;
    chk("fl_count", 32'(a_count), 0);
    chk("fl_empty", 32'(a_empty), 1);
    chk("fl_ovf", 32'(a_ovf), 0);
    chk("fl_pempty", 32'(a_pempty), 1);
    tick();
    chk("fl_discard", 32'(a_count), 0);
    a_din = 8'h55; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
    chk("fl_first", 32'(a_dout), 'h55);

    // threshold changes
    a_pf = 3'd0;
    tick();
    chk("th_pf0", 32'(a_pfull), 1);
    a_pf = 3'd6;
    tick();
    chk("th_pf6", 32'(a_pfull), 0);
    a_pe = 3'd0;
    tick();
    chk("th_pe0", 32'(a_pempty), 0);
    a_pf = 3'd4; a_pe = 3'd1;

    // standard-mode read path
    b_din = 8'hA5; b_wr = 1'b1;
    tick();
    b_din = 8'h5A;
    tick();
    b_wr = 1'b0;
    chk("std_idle_dv", 32'(b_dv), 0);
    b_rd = 1'b1;
    tick();
    b_rd = 1'b0;
    chk("std_dout1", 32'(b_dout), 'hA5);
    chk("std_dv1", 32'(b_dv), 1);
    tick();
    chk("std_dv1_off", 32'(b_dv), 0);
    chk("std_hold1", 32'(b_dout), 'hA5);
    b_rd = 1'b1;
    tick();
    b_rd = 1'b0;
    chk("std_dout2", 32'(b_dout), 'h5A);
    chk("std_dv2", 32'(b_dv), 1);
    tick();
    chk("std_hold2", 32'(b_dout), 'h5A);
    chk("std_dv2_off", 32'(b_dv), 0);
    chk("std_empty", 32'(b_empty), 1);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("std_clr_hold", 32'(b_dout), 'h5A);

    // reset mid-stream
    a_din = 8'h66; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
    chk("rs_pre_count", 32'(a_count), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_count", 32'(a_count), 0);
    chk("rs_empty", 32'(a_empty), 1);
    chk("rs_dout", 32'(a_dout), 0);
    chk("rs_pfull", 32'(a_pfull), 0);
    chk("rs_pempty", 32'(a_pempty), 1);
    chk("rs_b_dout", 32'(b_dout), 0);
    a_din = 8'h88; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
    chk("rs_first", 32'(a_dout), 'h88);
    chk("rs_first_count", 32'(a_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
